// File: rtl/and_reduce_monitor.sv
// ============================================================================
// Module   : and_reduce_monitor
// Brief    : Reduction-AND detector with registered copy, edge pulses and a
//            saturating high-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_reduce_monitor #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             clr_cnt,
  output logic             out,
  output logic             out_q,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] high_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_all;
  logic             r_out_q;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  // Combinational path stays live during reset.
  assign w_all = &in;
  assign out   = w_all;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_out_q <= w_all;
      r_rise  <= w_all & ~r_out_q;
      r_fall  <= ~w_all & r_out_q;
    end
  end

  // Clear beats a same-cycle count event; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (r_out_q && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  assign out_q    = r_out_q;
  assign rise     = r_rise;
  assign fall     = r_fall;
  assign high_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_and_reduce_monitor.sv
// Bench for and_reduce_monitor: directed scenarios plus random traffic against
// a history-based model; a wide-counter and a 2-bit-counter instance share inputs.
`default_nettype none

module tb_and_reduce_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  in = 3'b000;
  logic        clr_cnt = 1'b0;

  logic        out, out_q, rise, fall;
  logic [15:0] high_cnt;
  logic        s_out, s_out_q, s_rise, s_fall;
  logic [1:0]  s_high_cnt;

  int total = 0;
  int bad = 0;

  // Model: recent sampled values of "all inputs high" and number of counting edges since clear.
  bit samp[$];
  int m_ones = 0;

  and_reduce_monitor #(.WIDTH(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .clr_cnt(clr_cnt),
    .out(out), .out_q(out_q), .rise(rise), .fall(fall), .high_cnt(high_cnt)
  );

  and_reduce_monitor #(.WIDTH(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in(in), .clr_cnt(clr_cnt),
    .out(s_out), .out_q(s_out_q), .rise(s_rise), .fall(s_fall), .high_cnt(s_high_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_last();
    return (samp.size() > 0) ? samp[samp.size()-1] : 1'b0;
  endfunction

  function automatic bit m_prev();
    return (samp.size() > 1) ? samp[samp.size()-2] : 1'b0;
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock edge, fold it into the model, then settle 2 time units past the edge.
  task automatic cyc();
    bit old_q;
    @(posedge clk);
    if (rst_n) begin
      old_q = m_last();
      samp.push_back(in == 3'b111);
      if (samp.size() > 4) void'(samp.pop_front());
      if (clr_cnt) m_ones = 0;
      else if (old_q) m_ones++;
    end
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    samp.delete();
    m_ones = 0;
  endtask

  always @(negedge clk) begin
    chk("out", {31'b0, out}, {31'b0, in == 3'b111});
    chk("out_q", {31'b0, out_q}, {31'b0, m_last()});
    chk("rise", {31'b0, rise}, {31'b0, m_last() & ~m_prev()});
    chk("fall", {31'b0, fall}, {31'b0, ~m_last() & m_prev()});
    chk("high_cnt", {16'b0, high_cnt}, sat(m_ones, 65535));
    chk("sat_out_q", {31'b0, s_out_q}, {31'b0, m_last()});
    chk("sat_rise", {31'b0, s_rise}, {31'b0, m_last() & ~m_prev()});
    chk("sat_fall", {31'b0, s_fall}, {31'b0, ~m_last() & m_prev()});
    chk("sat_high_cnt", {30'b0, s_high_cnt}, sat(m_ones, 3));
  end

  initial begin
    int sat_exp[6];
    sat_exp = '{1, 2, 3, 3, 3, 3};

    // Truth table while held in reset.
    #1 in = 3'b000; #2;
    chk("tt_000", {31'b0, out}, 32'd0);
    #3 in = 3'b001; #2;
    chk("tt_001", {31'b0, out}, 32'd0);
    #3 in = 3'b111; #2;
    chk("tt_111", {31'b0, out}, 32'd1);
    chk("tt_regs", {12'b0, out_q, rise, fall, high_cnt}, 32'd0);

    @(posedge clk); #2;
    rst_n = 1'b1;
    in = 3'b000;

    // Exhaustive sweep.
    for (int v = 0; v < 8; v++) begin
      in = v[2:0];
      cyc();
    end
    in = 3'b000;
    clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;
    cyc(); cyc();

    // Edge pulses around a 4-cycle high window.
    in = 3'b111;
    cyc();
    chk("rise_pulse", {31'b0, rise}, 32'd1);
    cyc();
    chk("rise_once", {31'b0, rise}, 32'd0);
    cyc(); cyc();
    in = 3'b000;
    cyc();
    chk("fall_pulse", {31'b0, fall}, 32'd1);
    chk("cnt_after_win", {16'b0, high_cnt}, 32'd4);
    cyc();
    chk("fall_once", {31'b0, fall}, 32'd0);
    chk("cnt_hold", {16'b0, high_cnt}, 32'd4);

    // Clear priority and 2-bit saturation.
    in = 3'b111; clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("sat_seq", {30'b0, s_high_cnt}, sat_exp[k]);
    end
    cyc();
    chk("cnt_7", {16'b0, high_cnt}, 32'd7);
    clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;
    chk("clr_wins", {16'b0, high_cnt}, 32'd0);
    cyc();
    chk("resume_1", {16'b0, high_cnt}, 32'd1);
    cyc();
    chk("resume_2", {16'b0, high_cnt}, 32'd2);

    // Async reset between edges.
    clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    chk("cnt_5", {16'b0, high_cnt}, 32'd5);
    do_reset();
    #1;
    chk("arst_regs", {12'b0, out_q, rise, fall, high_cnt}, 32'd0);
    chk("arst_out", {31'b0, out}, 32'd1);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rise_after_rst", {31'b0, rise}, 32'd1);

    // Random traffic with occasional clears and async resets.
    for (int n = 0; n < 3000; n++) begin
      in = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 7));
      clr_cnt = ($urandom_range(0, 15) == 0);
      if (rst_n && $urandom_range(0, 199) == 0) do_reset();
      else if (!rst_n && $urandom_range(0, 2) == 0) rst_n = 1'b1;
      cyc();
    end
    rst_n = 1'b1;
    clr_cnt = 1'b0;
    in = 3'b111;
    for (int n = 0; n < 8; n++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
